branch_sched_ctrl: RTL and testbench
====================================

Name: branch_sched_ctrl

Overview:
- Branch scheduling controller for the pipelined core. It owns a direct-mapped BTB with 2-bit saturating counters.
- Fetch side: predicts taken/target from `if_pc`.
- EX side: takes the branch comparator's `branch_taken` result, detects mispredictions, and issues redirect plus flush to IF/ID and ID/EX.
- Includes a table-init sequencer and saturating statistics counters.

Parameters:
- XLEN, 32, address/data width.
- BTB_ENTRIES, 16, BTB entry count; power of 2, at least 2. IDX_W = log2(BTB_ENTRIES).
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- btb_clear  in  1  one-cycle pulse; re-initialise BTB
- init_busy  out  1  high while the INIT sweep runs; fetch may proceed, prediction forced not-taken
- if_pc  in  XLEN  fetch PC
- pred_taken  out  1  combinational prediction for if_pc
- pred_target  out  XLEN  predicted target; 0 when pred_taken=0
- ex_valid  in  1  EX stage holds a valid instruction
- ex_stall  in  1  EX stage held this cycle
- ex_is_branch  in  1  EX instruction is a conditional branch (beq/bne)
- ex_pc  in  XLEN  PC of EX instruction
- ex_target  in  XLEN  computed branch target
- ex_pred_taken  in  1  prediction carried down the pipe
- ex_pred_target  in  XLEN  predicted target carried down the pipe
- branch_taken  in  1  comparator result for EX instruction
- redirect_valid  out  1  fetch must load redirect_pc
- redirect_pc  out  XLEN  corrected PC
- flush_if_id  out  1  squash IF/ID register
- flush_id_ex  out  1  squash ID/EX register
- branch_cnt  out  CNT_W  resolved branches
- mispred_cnt  out  CNT_W  mispredicted branches

Behaviour:
- Reset (async, rst=1):
  - state=INIT, init_idx=0.
  - branch_cnt=0, mispred_cnt=0.
  - init_busy=1, pred_taken=0, pred_target=0.
  - redirect_valid=0, redirect_pc=0, flush_if_id=0, flush_id_ex=0.
  - BTB contents are don't-care until the sweep completes.
- FSM states INIT and RUN:
  - INIT: each cycle writes entry[init_idx] with valid=0, ctr=2'b01. init_idx increments each cycle. After writing index BTB_ENTRIES-1, the next state is RUN. The sweep therefore takes exactly BTB_ENTRIES cycles.
  - RUN: a btb_clear pulse sets state=INIT and init_idx=0 on the next edge.
  - btb_clear during INIT restarts the sweep from 0.
- Index/tag:
  - idx = pc[IDX_W+1:2].
  - tag = pc[XLEN-1:IDX_W+2].
- Lookup (combinational, RUN only):
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1].
  - pred_target = pred_taken ? entry.target : 0.
  - In INIT, pred_taken=0.
- Resolve event: fire = ex_valid & ~ex_stall & ex_is_branch. Only fire events update state or counters, so a stalled branch resolves exactly once.
- Redirect and flush (combinational, same cycle as fire):
  - mispredict = (branch_taken != ex_pred_taken) | (branch_taken & ex_pred_taken & (ex_pred_target != ex_target)).
  - redirect_valid = flush_if_id = flush_id_ex = fire & mispredict.
  - redirect_pc = branch_taken ? ex_target : ex_pc + 4, computed modulo 2^XLEN.
  - redirect_pc is 0 when redirect_valid=0.
  - Redirect is generated in INIT as well; correctness never depends on the table.
- BTB update (on clock edge after fire, RUN only, btb_clear not asserted):
  - Hit: ctr increments when taken (saturates at 3) and decrements when not taken (saturates at 0). On taken, target is rewritten with ex_target.
  - Miss and taken: allocate valid=1, tag, target=ex_target, ctr=2'b10.
  - Miss and not taken: no write.
  - In INIT, or when btb_clear is asserted in the same cycle, the update is dropped (clear wins).
- Same-index lookup and update in one cycle: the lookup returns the pre-update contents.
- Statistics (RUN and INIT alike):
  - On fire, branch_cnt increments; on fire & mispredict, mispred_cnt increments.
  - Both saturate at 2^CNT_W-1.
  - Cleared only by rst; btb_clear does not clear them.
- Reset mid-sweep or mid-resolve: immediate return to reset values; any pending update is lost.

Decomposition:
- Package `branch_pkg`:
  - typedef `btb_entry_t` {valid, tag, target, ctr[1:0]}
  - typedef `ctrl_state_e` {INIT, RUN}
  - localparams CTR_WEAK_NT=2'b01, CTR_WEAK_T=2'b10, PC_STEP=4
- Sub-module `sat_counter`, parameterised width, inc/dec with saturation.
  - Reused for the 2-bit BTB counters (inc and dec).
  - Reused for the CNT_W statistics counters (inc only).

Test Plan:
- Reset, then idle 16 cycles → init_busy=1 for exactly cycles 0–15 after reset release and 0 from cycle 16; pred_taken=0 throughout.
- After INIT, resolve a taken beq at ex_pc=0x100, ex_target=0x80, ex_pred_taken=0 → redirect_valid=1, redirect_pc=0x80, both flushes=1, mispred_cnt=1. The next lookup at if_pc=0x100 gives pred_taken=1, pred_target=0x80.
- Same branch resolved taken 2x more, then not-taken once with ex_pred_taken=1 → redirect_pc=0x104, ctr=2'b10 after the final resolve, so pred_taken is still 1.
- Fire with ex_stall=1 for 3 cycles, then ex_stall=0 → branch_cnt increments by exactly 1; redirect is asserted only in the unstalled cycle.
- btb_clear in the same cycle as a taken fire at 0x200 → redirect still issued; table re-sweeps; lookup at 0x200 after init_busy falls gives pred_taken=0.
- Drive CNT_W=4 with 20 fires → branch_cnt holds at 15.

Source files
------------

// File: rtl/branch_sched_ctrl_pkg.sv
// Shared types and constants for the branch scheduling controller.
// Entry fields are sized for the widest supported XLEN; narrower cores zero-extend.
package branch_pkg;

    localparam int unsigned XLEN_MAX    = 32;
    localparam logic [1:0]  CTR_WEAK_NT = 2'b01;
    localparam logic [1:0]  CTR_WEAK_T  = 2'b10;
    localparam int unsigned PC_STEP     = 4;

    typedef enum logic {
        INIT,
        RUN
    } ctrl_state_e;

    typedef struct packed {
        logic                valid;
        logic [XLEN_MAX-1:0] tag;
        logic [XLEN_MAX-1:0] target;
        logic [1:0]          ctr;
    } btb_entry_t;

endpackage

// File: rtl/branch_sched_ctrl_sat_counter.sv
// Saturating up/down counter next-value logic; the caller owns the register.
module sat_counter #(
    parameter int unsigned W = 2
) (
    input  logic [W-1:0] value,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] next
);

    always_comb begin
        next = value;
        if (inc && !dec && value != '1) begin
            next = value + W'(1);
        end else if (dec && !inc && value != '0) begin
            next = value - W'(1);
        end
    end

endmodule

// File: rtl/branch_sched_ctrl.sv
// Branch scheduling controller: direct-mapped BTB prediction at fetch,
// misprediction redirect/flush at EX, table-init sweep and resolve statistics.
module branch_sched_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            btb_clear,
    output logic            init_busy,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic            ex_stall,
    input  logic            ex_is_branch,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    input  logic            branch_taken,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);

    ctrl_state_e      state, state_nx;
    logic [IDX_W-1:0] init_idx, init_idx_nx;
    btb_entry_t       btb [BTB_ENTRIES];

    // Word addresses: byte-offset bits never take part in index or tag.
    logic [XLEN-3:0]       if_word, ex_word;
    logic [IDX_W-1:0]      if_idx, ex_idx;
    logic [XLEN-3-IDX_W:0] if_tag, ex_tag;
    btb_entry_t            if_ent, ex_ent, upd_ent;
    logic                  if_hit, ex_hit;
    logic                  fire, mispredict, upd_en;
    logic [1:0]            ex_ctr_nx;
    logic [CNT_W-1:0]      branch_cnt_nx, mispred_cnt_nx;

    assign if_word = (XLEN-2)'(if_pc >> 2);
    assign ex_word = (XLEN-2)'(ex_pc >> 2);
    assign if_idx  = if_word[IDX_W-1:0];
    assign if_tag  = if_word[XLEN-3:IDX_W];
    assign ex_idx  = ex_word[IDX_W-1:0];
    assign ex_tag  = ex_word[XLEN-3:IDX_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            init_idx <= '0;
        end else begin
            state    <= state_nx;
            init_idx <= init_idx_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        init_idx_nx = init_idx;
        case (state)
            INIT: begin
                init_idx_nx = init_idx + IDX_W'(1);
                if (init_idx == IDX_W'(BTB_ENTRIES - 1)) begin
                    state_nx = RUN;
                end
            end
            RUN:     state_nx = RUN;
            default: state_nx = INIT;
        endcase
        if (btb_clear) begin
            state_nx    = INIT;
            init_idx_nx = '0;
        end
    end

    assign init_busy = (state == INIT);

    always_comb begin
        if_ent      = btb[if_idx];
        if_hit      = if_ent.valid && (if_ent.tag == XLEN_MAX'(if_tag));
        pred_taken  = (state == RUN) && if_hit && if_ent.ctr[1];
        pred_target = pred_taken ? XLEN'(if_ent.target) : '0;
    end

    always_comb begin
        fire       = ex_valid && !ex_stall && ex_is_branch;
        mispredict = (branch_taken != ex_pred_taken) ||
                     (branch_taken && ex_pred_taken && (ex_pred_target != ex_target));
        redirect_valid = fire && mispredict;
        flush_if_id    = redirect_valid;
        flush_id_ex    = redirect_valid;
        redirect_pc    = '0;
        if (redirect_valid) begin
            redirect_pc = branch_taken ? ex_target : ex_pc + XLEN'(PC_STEP);
        end
    end

    sat_counter #(.W(2)) u_btb_ctr (
        .value (ex_ent.ctr),
        .inc   (branch_taken),
        .dec   (!branch_taken),
        .next  (ex_ctr_nx)
    );

    always_comb begin
        ex_ent  = btb[ex_idx];
        ex_hit  = ex_ent.valid && (ex_ent.tag == XLEN_MAX'(ex_tag));
        upd_ent = ex_ent;
        if (ex_hit) begin
            upd_ent.ctr = ex_ctr_nx;
            if (branch_taken) begin
                upd_ent.target = XLEN_MAX'(ex_target);
            end
        end else begin
            upd_ent = '{valid: 1'b1, tag: XLEN_MAX'(ex_tag),
                        target: XLEN_MAX'(ex_target), ctr: CTR_WEAK_T};
        end
        upd_en = fire && (state == RUN) && !btb_clear && (ex_hit || branch_taken);
    end

    // Table storage has no reset; the INIT sweep establishes its contents.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            btb[init_idx] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WEAK_NT};
        end else if (upd_en) begin
            btb[ex_idx] <= upd_ent;
        end
    end

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .value (branch_cnt),
        .inc   (fire),
        .dec   (1'b0),
        .next  (branch_cnt_nx)
    );

    sat_counter #(.W(CNT_W)) u_mispred_cnt (
        .value (mispred_cnt),
        .inc   (redirect_valid),
        .dec   (1'b0),
        .next  (mispred_cnt_nx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            branch_cnt  <= branch_cnt_nx;
            mispred_cnt <= mispred_cnt_nx;
        end
    end

endmodule

// File: tb/tb_branch_sched_ctrl.sv
// Scoreboard bench for branch_sched_ctrl: expected redirects are queued as
// branches are driven and popped when the combinational outputs settle.
module tb_branch_sched_ctrl;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned BTB_ENTRIES = 16;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned CNT_MAX     = 15;

    logic             clk = 1'b0;
    logic             rst, btb_clear, init_busy;
    logic [XLEN-1:0]  if_pc, pred_target;
    logic             pred_taken;
    logic             ex_valid, ex_stall, ex_is_branch, ex_pred_taken, branch_taken;
    logic [XLEN-1:0]  ex_pc, ex_target, ex_pred_target;
    logic             redirect_valid, flush_if_id, flush_id_ex;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] branch_cnt, mispred_cnt;

    always #5 clk = ~clk;

    branch_sched_ctrl #(.XLEN(XLEN), .BTB_ENTRIES(BTB_ENTRIES), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .btb_clear      (btb_clear),
        .init_busy      (init_busy),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_stall       (ex_stall),
        .ex_is_branch   (ex_is_branch),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .branch_taken   (branch_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    typedef struct {
        logic            rv;
        logic [XLEN-1:0] pc;
    } exp_t;

    typedef struct {
        logic [31:0] pc, tgt;
        logic        pt;
        logic [31:0] ptgt;
        logic        tk, rv;
        logic [31:0] rpc, lk_pc;
        logic        lk_t;
        logic [31:0] lk_tgt;
    } case_t;

    exp_t        sb[$];
    exp_t        exp_r;
    int          passed = 0;
    int          total  = 0;
    int unsigned exp_branch  = 0;
    int unsigned exp_mispred = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_stall = 1'b0; ex_is_branch = 1'b0;
        ex_pc = '0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
        branch_taken = 1'b0; btb_clear = 1'b0;
    endtask

    task automatic resolve(input logic [31:0] pc, tgt, input logic pt, input logic [31:0] ptgt,
                           input logic tk, stall, exp_rv, input logic [31:0] exp_pc);
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_stall = stall;
        ex_pc = pc; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
        branch_taken = tk;
        sb.push_back('{exp_rv, exp_pc});
        if (!stall) begin
            if (exp_branch < CNT_MAX) exp_branch++;
            if (exp_rv && exp_mispred < CNT_MAX) exp_mispred++;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        if_pc = '0;
        rst = 1'b1;
        step();
        step();
        total++;
        if ({init_busy, pred_taken, pred_target, redirect_valid, redirect_pc, flush_if_id,
             flush_id_ex, branch_cnt, mispred_cnt} !==
            {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0})
            $display("FAIL reset_values: busy=%b pt=%b ptgt=%h rv=%b rpc=%h f=%b%b bc=%0d mc=%0d, want busy=1 rest 0",
                     init_busy, pred_taken, pred_target, redirect_valid, redirect_pc,
                     flush_if_id, flush_id_ex, branch_cnt, mispred_cnt);
        else passed++;
        rst = 1'b0;
        for (int c = 0; c <= 16; c++) begin
            if_pc = XLEN'(c * 4);
            #2;
            total++;
            if (init_busy !== (c < 16) || pred_taken !== 1'b0)
                $display("FAIL init_sweep_cycle_%0d: busy=%b pt=%b, want busy=%b pt=0",
                         c, init_busy, pred_taken, (c < 16));
            else passed++;
            step();
        end
    endtask

    task automatic test_predict_train();
        case_t cases[9];
        cases[0] = '{32'h100, 32'h80, 1'b0, 32'h0,  1'b1, 1'b1, 32'h80,  32'h100, 1'b1, 32'h80};
        cases[1] = '{32'h100, 32'h80, 1'b1, 32'h80, 1'b1, 1'b0, 32'h0,   32'h100, 1'b1, 32'h80};
        cases[2] = '{32'h100, 32'h80, 1'b1, 32'h80, 1'b1, 1'b0, 32'h0,   32'h100, 1'b1, 32'h80};
        cases[3] = '{32'h100, 32'h80, 1'b1, 32'h80, 1'b0, 1'b1, 32'h104, 32'h100, 1'b1, 32'h80};
        cases[4] = '{32'h148, 32'h90, 1'b1, 32'h80, 1'b1, 1'b1, 32'h90,  32'h148, 1'b1, 32'h90};
        cases[5] = '{32'h100, 32'h80, 1'b1, 32'h80, 1'b0, 1'b1, 32'h104, 32'h100, 1'b0, 32'h0};
        cases[6] = '{32'h100, 32'h80, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h500, 1'b0, 32'h0};
        cases[7] = '{32'h100, 32'h80, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h100, 1'b0, 32'h0};
        cases[8] = '{32'h100, 32'h80, 1'b0, 32'h0,  1'b1, 1'b1, 32'h80,  32'h100, 1'b0, 32'h0};
        for (int i = 0; i < 9; i++) begin
            resolve(cases[i].pc, cases[i].tgt, cases[i].pt, cases[i].ptgt, cases[i].tk,
                    1'b0, cases[i].rv, cases[i].rpc);
            #2;
            exp_r = sb.pop_front();
            total++;
            if ({redirect_valid, flush_if_id, flush_id_ex, redirect_pc} !==
                {exp_r.rv, exp_r.rv, exp_r.rv, exp_r.pc})
                $display("FAIL train_redirect_%0d: rv=%b f=%b%b pc=%h, want rv=%b pc=%h",
                         i, redirect_valid, flush_if_id, flush_id_ex, redirect_pc, exp_r.rv, exp_r.pc);
            else passed++;
            step();
            idle_inputs();
            if_pc = cases[i].lk_pc;
            #1;
            total++;
            if (pred_taken !== cases[i].lk_t || pred_target !== cases[i].lk_tgt)
                $display("FAIL train_lookup_%0d: pt=%b ptgt=%h, want pt=%b ptgt=%h",
                         i, pred_taken, pred_target, cases[i].lk_t, cases[i].lk_tgt);
            else passed++;
            total++;
            if (branch_cnt !== CNT_W'(exp_branch) || mispred_cnt !== CNT_W'(exp_mispred))
                $display("FAIL train_counts_%0d: bc=%0d mc=%0d, want bc=%0d mc=%0d",
                         i, branch_cnt, mispred_cnt, exp_branch, exp_mispred);
            else passed++;
        end
    endtask

    task automatic test_stall();
        for (int s = 0; s < 4; s++) begin
            resolve(32'h30C, 32'h340, 1'b0, 32'h0, 1'b1, (s < 3), (s == 3),
                    (s == 3) ? 32'h340 : 32'h0);
            #2;
            exp_r = sb.pop_front();
            total++;
            if ({redirect_valid, flush_if_id, flush_id_ex, redirect_pc} !==
                {exp_r.rv, exp_r.rv, exp_r.rv, exp_r.pc})
                $display("FAIL stall_redirect_%0d: rv=%b f=%b%b pc=%h, want rv=%b pc=%h",
                         s, redirect_valid, flush_if_id, flush_id_ex, redirect_pc, exp_r.rv, exp_r.pc);
            else passed++;
            step();
            total++;
            if (branch_cnt !== CNT_W'(exp_branch) || mispred_cnt !== CNT_W'(exp_mispred))
                $display("FAIL stall_counts_%0d: bc=%0d mc=%0d, want bc=%0d mc=%0d",
                         s, branch_cnt, mispred_cnt, exp_branch, exp_mispred);
            else passed++;
        end
        idle_inputs();
    endtask

    task automatic test_clear();
        int n;
        resolve(32'h200, 32'h280, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h280);
        btb_clear = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #2;
            exp_r = sb.pop_front();
            total++;
            if ({redirect_valid, flush_if_id, flush_id_ex, redirect_pc} !==
                {exp_r.rv, exp_r.rv, exp_r.rv, exp_r.pc})
                $display("FAIL clear_redirect_%0d: rv=%b f=%b%b pc=%h, want rv=%b pc=%h",
                         k, redirect_valid, flush_if_id, flush_id_ex, redirect_pc, exp_r.rv, exp_r.pc);
            else passed++;
            step();
            idle_inputs();
            total++;
            if (init_busy !== 1'b1)
                $display("FAIL clear_busy_%0d: busy=%b, want 1", k, init_busy);
            else passed++;
            if (k == 0) begin
                step(); step(); step();
                resolve(32'h200, 32'h280, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h280);
            end
        end
        btb_clear = 1'b1;
        step();
        btb_clear = 1'b0;
        n = 0;
        while (init_busy === 1'b1 && n < 40) begin
            step();
            n++;
        end
        total++;
        if (n != 16)
            $display("FAIL clear_sweep_len: cycles=%0d, want 16", n);
        else passed++;
        if_pc = 32'h200;
        #1;
        total++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h0)
            $display("FAIL clear_lookup_200: pt=%b ptgt=%h, want pt=0 ptgt=0", pred_taken, pred_target);
        else passed++;
        if_pc = 32'h148;
        #1;
        total++;
        if (pred_taken !== 1'b0)
            $display("FAIL clear_lookup_148: pt=%b, want 0", pred_taken);
        else passed++;
        total++;
        if (branch_cnt !== CNT_W'(exp_branch) || mispred_cnt !== CNT_W'(exp_mispred))
            $display("FAIL clear_counts: bc=%0d mc=%0d, want bc=%0d mc=%0d",
                     branch_cnt, mispred_cnt, exp_branch, exp_mispred);
        else passed++;
    endtask

    task automatic test_saturate();
        step();
        for (int i = 0; i < 20; i++) begin
            resolve(32'h400 + 32'(i * 4), 32'h600, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h600);
            #2;
            exp_r = sb.pop_front();
            total++;
            if ({redirect_valid, redirect_pc} !== {exp_r.rv, exp_r.pc})
                $display("FAIL sat_redirect_%0d: rv=%b pc=%h, want rv=%b pc=%h",
                         i, redirect_valid, redirect_pc, exp_r.rv, exp_r.pc);
            else passed++;
            step();
            total++;
            if (branch_cnt !== CNT_W'(exp_branch) || mispred_cnt !== CNT_W'(exp_mispred))
                $display("FAIL sat_counts_%0d: bc=%0d mc=%0d, want bc=%0d mc=%0d",
                         i, branch_cnt, mispred_cnt, exp_branch, exp_mispred);
            else passed++;
        end
        idle_inputs();
        step();
        total++;
        if (branch_cnt !== 4'hF || mispred_cnt !== 4'hF)
            $display("FAIL sat_final: bc=%0d mc=%0d, want bc=15 mc=15", branch_cnt, mispred_cnt);
        else passed++;
    endtask

    task automatic test_reset_mid();
        ex_valid = 1'b1; ex_is_branch = 1'b1; branch_taken = 1'b1; ex_pc = 32'h700;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({init_busy, pred_taken, branch_cnt, mispred_cnt} !== {1'b1, 1'b0, 4'h0, 4'h0})
            $display("FAIL reset_mid: busy=%b pt=%b bc=%0d mc=%0d, want busy=1 pt=0 bc=0 mc=0",
                     init_busy, pred_taken, branch_cnt, mispred_cnt);
        else passed++;
        idle_inputs();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_predict_train();
        test_stall();
        test_clear();
        test_saturate();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
